cis_frame_sequencer: RTL and testbench
======================================

Name: cis_frame_sequencer

Overview:
- Sequences CIS_Control across a frame of rows.
- Per row: times the exposure, issues the `integration` trigger pulse, and waits for the `running` handshake from CIS_Control to rise and fall.
- After each row: applies a settle gap, then advances the row address.
- Sits between the register/readout controller and CIS_Control, replacing manual triggering.

Parameters:
- ROW_W, 10, width of row count/address.
- CNT_W, 24, width of exposure/settle counters.
- TRIG_WIDTH, 50, integration pulse width in clk cycles (must be >> 1 clk; CIS_Control samples it on its divided clock).
- START_TIMEOUT, 4096, max cycles from trigger rise to `running` rise before error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low (asserted when 0)
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  abandon frame from any state
- num_rows  in  ROW_W  rows per frame; latched on start
- exposure_ticks  in  CNT_W  cycles of exposure before each trigger; latched on start
- settle_ticks  in  CNT_W  idle cycles after each row; latched on start
- running  in  1  from CIS_Control: pattern sequence active
- integration  out  1  trigger to CIS_Control
- row_addr  out  ROW_W  current row index, 0..num_rows-1
- busy  out  1  high whenever state != IDLE
- row_done  out  1  1-cycle pulse when a row's running falls
- frame_done  out  1  1-cycle pulse after last row settles
- error  out  1  sticky start-timeout flag; cleared on next accepted start

Behaviour:
- Reset (async assert): state=IDLE; all outputs 0; counters and latched config 0. Deassertion is synchronised internally (2-flop).
- FSM states: IDLE, EXPOSE, TRIGGER, WAIT_RUN, WAIT_DONE, SETTLE, DONE.
- IDLE: on start with num_rows != 0, latch config, clear error, row_addr=0, go to EXPOSE next cycle (busy=1 at t+1).
- IDLE, start with num_rows == 0: go to DONE; frame_done pulses at t+1; no trigger issued.
- EXPOSE: count exposure_ticks cycles, then TRIGGER. exposure_ticks == 0 goes straight to TRIGGER (no dead cycle).
- TRIGGER: integration=1 for exactly TRIG_WIDTH consecutive cycles, then WAIT_RUN.
  - Timeout counter starts at the first TRIGGER cycle.
  - `running` seen high during TRIGGER is remembered.
- WAIT_RUN: proceed to WAIT_DONE once `running` has been seen high (during TRIGGER or here).
- Timeout: if `running` has not been seen high by START_TIMEOUT cycles after trigger rise:
  - error=1, go to IDLE, integration=0;
  - no row_done or frame_done pulse.
- WAIT_DONE: on `running`==0, pulse row_done, go to SETTLE. No timeout here: skipping length is programmable.
- SETTLE: count settle_ticks cycles (0 means a single pass-through cycle).
  - If row_addr == num_rows-1, go to DONE.
  - Else row_addr += 1 and go to EXPOSE.
- DONE: frame_done=1 for one cycle, then IDLE. busy drops in the same cycle frame_done drops.
- abort (any non-IDLE state): next cycle state=IDLE, integration=0, busy=0; counters cleared; row_addr holds last value; no done pulses; error unchanged. abort has priority over start in the same cycle.
- start while busy is ignored. Changing config inputs mid-frame has no effect.
- row_addr never wraps: compare is against latched num_rows-1. num_rows = 2^ROW_W-1 is legal.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package cis_seq_pkg holds:
  - state enum typedef;
  - localparam for the synchroniser depth;
  - shared ROW_W/CNT_W defaults, so CIS_Control wrappers match.
- One sub-module, cis_seq_timer: loadable down-counter with zero flag.
  - Used for exposure, trigger width and settle (time-multiplexed, one instance).
  - The timeout counter is separate, inline.

Test Plan:
- Bench drives a behavioural CIS_Control model: running rises 3 cycles after integration rises, stays high 40 cycles after integration falls.
- Basic frame: num_rows=3, exposure=10, settle=5
  -> 3 integration pulses each exactly 50 cycles;
  -> row_addr 0,1,2;
  -> 3 row_done pulses;
  -> frame_done once;
  -> busy high from start+1 to frame_done.
- Zero cases: exposure=0, settle=0, num_rows=1 -> integration rises at start+2. Separately, num_rows=0 -> frame_done at start+1, integration never asserted.
- Timeout: model never raises running, START_TIMEOUT=200 -> error=1 at trigger_rise+200, FSM IDLE, no done pulses. Next start clears error.
- Abort: abort during second row's WAIT_DONE -> IDLE next cycle, integration=0, row_addr=1, no frame_done. A start issued in the same cycle as abort is ignored.
- Reset mid-frame: drive reset=0 asynchronously during TRIGGER -> integration=0 immediately (before next clk edge), all outputs 0. After release, new start runs a clean frame.
- Early running: model raises running during TRIGGER cycle 1 -> no timeout, row completes normally. start pulses while busy are ignored.

Source files
------------

// File: rtl/cis_seq_pkg.sv
// Shared types and defaults for the CIS frame sequencer and its CIS_Control wrappers.
// Default row/counter widths live here so both sides agree on port widths.
package cis_seq_pkg;

  localparam int ROW_W_DEF   = 10;
  localparam int CNT_W_DEF   = 24;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPOSE,
    S_TRIGGER,
    S_WAIT_RUN,
    S_WAIT_DONE,
    S_SETTLE,
    S_DONE
  } state_t;

endpackage

// File: rtl/cis_seq_timer.sv
// Loadable down-counter with a zero flag; one instance is shared by the exposure,
// trigger-width and settle phases. Load takes effect on the next edge; holds at zero.
module cis_seq_timer #(
  parameter int W = 24
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cis_frame_sequencer.sv
// Frame sequencer for CIS_Control: per row expose, trigger, wait for running, settle.
// All outputs registered; start is taken one cycle after it is sampled in IDLE.
module cis_frame_sequencer
  import cis_seq_pkg::*;
#(
  parameter int ROW_W         = ROW_W_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int TRIG_WIDTH    = 50,
  parameter int START_TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [ROW_W-1:0] i_num_rows,
  input  logic [CNT_W-1:0] i_exposure_ticks,
  input  logic [CNT_W-1:0] i_settle_ticks,
  input  logic             i_running,
  output logic             o_integration,
  output logic [ROW_W-1:0] o_row_addr,
  output logic             o_busy,
  output logic             o_row_done,
  output logic             o_frame_done,
  output logic             o_error
);

  localparam int               TMO_W     = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TRIG_LOAD = CNT_W'(TRIG_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(START_TIMEOUT - 1);

  // A phase of N ticks lasts N cycles; zero still costs the one cycle spent in the state.
  function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] ticks);
    return (ticks == '0) ? '0 : ticks - CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic                   w_rst_n;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[SYNC_STAGES-1];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ROW_W-1:0] r_num_rows;
  logic [ROW_W-1:0] r_row_addr;
  logic [ROW_W-1:0] w_row_addr_nxt;
  logic [CNT_W-1:0] r_exposure;
  logic [CNT_W-1:0] r_settle;
  logic [TMO_W-1:0] r_tmo;
  logic             r_run_seen;
  logic             w_seen;
  logic             w_tmo_hit;
  logic             w_last_row;
  logic             w_accept;
  logic             w_row_fin;
  logic             w_err_set;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_zero;
  logic             w_in_start_wait;
  logic             w_nxt_start_wait;

  logic r_integration, r_busy, r_row_done, r_frame_done, r_error;
  logic w_integration_nxt, w_busy_nxt, w_row_done_nxt, w_frame_done_nxt, w_error_nxt;

  cis_seq_timer #(
    .W(CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (w_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  assign w_seen           = r_run_seen | i_running;
  assign w_tmo_hit        = (r_tmo == TMO_LAST) && !w_seen;
  assign w_last_row       = (r_row_addr == r_num_rows - ROW_W'(1));
  assign w_accept         = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_in_start_wait  = (r_state == S_TRIGGER) || (r_state == S_WAIT_RUN);
  assign w_nxt_start_wait = (w_state_nxt == S_TRIGGER) || (w_state_nxt == S_WAIT_RUN);

  always_comb begin
    w_state_nxt    = r_state;
    w_row_addr_nxt = r_row_addr;
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;
    w_row_fin      = 1'b0;
    w_err_set      = 1'b0;
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_tmr_load  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_row_addr_nxt = '0;
            if (i_num_rows == '0) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_EXPOSE;
              w_tmr_load  = 1'b1;
              w_tmr_val   = f_load(i_exposure_ticks);
            end
          end
        end
        S_EXPOSE: begin
          if (w_tmr_zero) begin
            w_state_nxt = S_TRIGGER;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TRIG_LOAD;
          end
        end
        S_TRIGGER: begin
          if (w_tmo_hit) begin
            w_state_nxt = S_IDLE;
            w_err_set   = 1'b1;
            w_tmr_load  = 1'b1;
          end else if (w_tmr_zero) begin
            w_state_nxt = S_WAIT_RUN;
          end
        end
        S_WAIT_RUN: begin
          if (w_seen) begin
            w_state_nxt = S_WAIT_DONE;
          end else if (w_tmo_hit) begin
            w_state_nxt = S_IDLE;
            w_err_set   = 1'b1;
            w_tmr_load  = 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!i_running) begin
            w_state_nxt = S_SETTLE;
            w_row_fin   = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = f_load(r_settle);
          end
        end
        S_SETTLE: begin
          if (w_tmr_zero) begin
            if (w_last_row) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt    = S_EXPOSE;
              w_row_addr_nxt = r_row_addr + ROW_W'(1);
              w_tmr_load     = 1'b1;
              w_tmr_val      = f_load(r_exposure);
            end
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_integration_nxt = (w_state_nxt == S_TRIGGER);
    w_busy_nxt        = (w_state_nxt != S_IDLE);
    w_frame_done_nxt  = (w_state_nxt == S_DONE);
    w_row_done_nxt    = w_row_fin;
    w_error_nxt       = w_accept ? 1'b0 : (r_error | w_err_set);
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= S_IDLE;
      r_row_addr    <= '0;
      r_num_rows    <= '0;
      r_exposure    <= '0;
      r_settle      <= '0;
      r_tmo         <= '0;
      r_run_seen    <= 1'b0;
      r_integration <= 1'b0;
      r_busy        <= 1'b0;
      r_row_done    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row_addr    <= w_row_addr_nxt;
      r_integration <= w_integration_nxt;
      r_busy        <= w_busy_nxt;
      r_row_done    <= w_row_done_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_error       <= w_error_nxt;
      if (w_accept) begin
        r_num_rows <= i_num_rows;
        r_exposure <= i_exposure_ticks;
        r_settle   <= i_settle_ticks;
      end
      // Timeout runs from the first trigger cycle and clears on any exit.
      r_tmo <= (w_in_start_wait && w_nxt_start_wait) ? r_tmo + TMO_W'(1) : '0;
      if ((r_state == S_EXPOSE) || (w_state_nxt == S_IDLE)) begin
        r_run_seen <= 1'b0;
      end else if (w_in_start_wait && i_running) begin
        r_run_seen <= 1'b1;
      end
    end
  end

  assign o_integration = r_integration;
  assign o_row_addr    = r_row_addr;
  assign o_busy        = r_busy;
  assign o_row_done    = r_row_done;
  assign o_frame_done  = r_frame_done;
  assign o_error       = r_error;

endmodule

// File: tb/tb_cis_frame_sequencer.sv
// Directed bench for cis_frame_sequencer with a behavioural CIS_Control model.
// Cycle k counts clock periods after the edge that samples start (k=1 is start+1).
module tb_cis_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  num_rows = '0;
  logic [23:0] exposure = '0;
  logic [23:0] settle = '0;
  logic        running = 1'b0;
  logic        o_integration, o_busy, o_row_done, o_frame_done, o_error;
  logic [9:0]  o_row_addr;

  int n_tests = 0;
  int n_fail = 0;

  // Model mode: 0 never raises running, 1 rises 3 cycles after trigger, 2 rises on trigger cycle 1.
  int mode = 1;
  int m_hi = 0;
  int m_fall = 0;

  int g_k, first_rise, rise_cnt, hi_len, width_bad, rd_cnt, fd_cnt, fd_k;
  int busy_hi, busy_lo, err_k;
  logic busy1, err1, busy_after, err_busy, prev_int;
  logic [9:0] rise_row [4];
  logic [14:0] outs;
  logic [14:0] zeros = '0;

  cis_frame_sequencer #(
    .ROW_W(10), .CNT_W(24), .TRIG_WIDTH(50), .START_TIMEOUT(200)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_start          (start),
    .i_abort          (abort),
    .i_num_rows       (num_rows),
    .i_exposure_ticks (exposure),
    .i_settle_ticks   (settle),
    .i_running        (running),
    .o_integration    (o_integration),
    .o_row_addr       (o_row_addr),
    .o_busy           (o_busy),
    .o_row_done       (o_row_done),
    .o_frame_done     (o_frame_done),
    .o_error          (o_error)
  );

  always #5 clk = ~clk;

  assign outs = {o_integration, o_busy, o_row_done, o_frame_done, o_error, o_row_addr};

  always @(negedge clk) begin
    if (!rst_n || mode == 0) begin
      running = 1'b0;
      m_hi    = 0;
      m_fall  = 0;
    end else if (o_integration) begin
      m_hi++;
      m_fall = 0;
      if ((mode == 2 && m_hi == 1) || (mode == 1 && m_hi == 4)) running = 1'b1;
    end else begin
      m_hi = 0;
      if (running) begin
        m_fall++;
        if (m_fall == 40) begin
          running = 1'b0;
          m_fall  = 0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_stats;
    first_rise = -1; rise_cnt = 0; hi_len = 0; width_bad = 0; rd_cnt = 0;
    fd_cnt = 0; fd_k = -1; busy_hi = 0; busy_lo = 0; err_k = -1;
    busy1 = 1'bx; err1 = 1'bx; busy_after = 1'bx; err_busy = 1'bx; prev_int = 1'b0;
    for (int i = 0; i < 4; i++) rise_row[i] = '1;
  endtask

  task automatic start_frame(input logic [9:0] nr, input logic [23:0] ex, input logic [23:0] st);
    num_rows = nr;
    exposure = ex;
    settle   = st;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g_k   = 0;
    clear_stats();
  endtask

  // Samples n cycles at negedges; optionally stops one cycle after frame_done.
  task automatic observe(input int n, input bit stop_fd);
    for (int i = 0; i < n; i++) begin
      g_k++;
      if (g_k == 1) begin busy1 = o_busy; err1 = o_error; end
      if (o_integration && !prev_int) begin
        if (first_rise < 0) first_rise = g_k;
        if (rise_cnt < 4) rise_row[rise_cnt] = o_row_addr;
        rise_cnt++;
        hi_len = 0;
      end
      if (o_integration) hi_len++;
      else if (prev_int && hi_len != 50) width_bad++;
      prev_int = o_integration;
      if (o_row_done) rd_cnt++;
      if (o_frame_done) begin fd_cnt++; if (fd_k < 0) fd_k = g_k; end
      if (o_busy) busy_hi++;
      if (!o_busy && fd_k < 0) busy_lo++;
      if (o_error && err_k < 0) begin err_k = g_k; err_busy = o_busy; end
      if (fd_k >= 0 && g_k == fd_k + 1) busy_after = o_busy;
      @(negedge clk);
      if (stop_fd && fd_k >= 0 && g_k > fd_k) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (outs !== zeros) begin n_fail++; $display("FAIL reset_asserted outs=%h exp=%h", outs, zeros); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++; if (outs !== zeros) begin n_fail++; $display("FAIL reset_released outs=%h exp=%h", outs, zeros); end
  endtask

  task automatic test_basic_frame;
    mode = 1;
    start_frame(10'd3, 24'd10, 24'd5);
    observe(400, 1'b1);
    n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_1 got=%b exp=1", busy1); end
    n_tests++; if (first_rise != 11) begin n_fail++; $display("FAIL basic_first_rise got=%0d exp=11", first_rise); end
    n_tests++; if (rise_cnt != 3) begin n_fail++; $display("FAIL basic_rise_count got=%0d exp=3", rise_cnt); end
    n_tests++; if (width_bad != 0) begin n_fail++; $display("FAIL basic_pulse_width bad=%0d exp=0", width_bad); end
    n_tests++; if ({rise_row[0], rise_row[1], rise_row[2]} !== {10'd0, 10'd1, 10'd2}) begin
      n_fail++; $display("FAIL basic_row_addr got=%0d,%0d,%0d exp=0,1,2", rise_row[0], rise_row[1], rise_row[2]); end
    n_tests++; if (rd_cnt != 3) begin n_fail++; $display("FAIL basic_row_done got=%0d exp=3", rd_cnt); end
    n_tests++; if (fd_k != 316 || fd_cnt != 1) begin n_fail++; $display("FAIL basic_frame_done at=%0d cnt=%0d exp at=316 cnt=1", fd_k, fd_cnt); end
    n_tests++; if (busy_lo != 0) begin n_fail++; $display("FAIL basic_busy_gap low_cycles=%0d exp=0", busy_lo); end
    n_tests++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_done got=%b exp=0", busy_after); end
  endtask

  task automatic test_zero_cases;
    mode = 1;
    start_frame(10'd1, 24'd0, 24'd0);
    observe(200, 1'b1);
    n_tests++; if (first_rise != 2) begin n_fail++; $display("FAIL zero_trigger_rise got=%0d exp=2", first_rise); end
    n_tests++; if (fd_k != 93 || rd_cnt != 1) begin n_fail++; $display("FAIL zero_frame_done at=%0d rows=%0d exp at=93 rows=1", fd_k, rd_cnt); end
    start_frame(10'd0, 24'd7, 24'd7);
    observe(10, 1'b0);
    n_tests++; if (fd_k != 1 || fd_cnt != 1) begin n_fail++; $display("FAIL zero_rows_done at=%0d cnt=%0d exp at=1 cnt=1", fd_k, fd_cnt); end
    n_tests++; if (rise_cnt != 0) begin n_fail++; $display("FAIL zero_rows_trigger got=%0d exp=0", rise_cnt); end
    n_tests++; if (busy1 !== 1'b1 || busy_after !== 1'b0) begin n_fail++; $display("FAIL zero_rows_busy got=%b%b exp=10", busy1, busy_after); end
  endtask

  task automatic test_timeout;
    mode = 0;
    start_frame(10'd2, 24'd0, 24'd0);
    observe(210, 1'b0);
    n_tests++; if (err_k != 202) begin n_fail++; $display("FAIL timeout_error_cycle got=%0d exp=202", err_k); end
    n_tests++; if (err_busy !== 1'b0 || busy_hi != 201) begin n_fail++; $display("FAIL timeout_idle busy=%b busy_cycles=%0d exp busy=0 cycles=201", err_busy, busy_hi); end
    n_tests++; if (rd_cnt != 0 || fd_cnt != 0) begin n_fail++; $display("FAIL timeout_no_done rows=%0d frames=%0d exp=0,0", rd_cnt, fd_cnt); end
    n_tests++; if (o_error !== 1'b1 || o_integration !== 1'b0) begin n_fail++; $display("FAIL timeout_sticky err=%b int=%b exp err=1 int=0", o_error, o_integration); end
    mode = 1;
    start_frame(10'd1, 24'd0, 24'd0);
    observe(200, 1'b1);
    n_tests++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL timeout_error_clear got=%b exp=0", err1); end
    n_tests++; if (fd_k != 93) begin n_fail++; $display("FAIL timeout_recover_frame at=%0d exp=93", fd_k); end
  endtask

  task automatic test_abort;
    mode = 1;
    start_frame(10'd3, 24'd10, 24'd5);
    observe(179, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    observe(1, 1'b0);
    abort = 1'b0;
    start = 1'b0;
    n_tests++; if (rd_cnt != 1) begin n_fail++; $display("FAIL abort_pre_rows got=%0d exp=1", rd_cnt); end
    n_tests++; if ({o_busy, o_integration} !== 2'b00) begin n_fail++; $display("FAIL abort_idle busy=%b int=%b exp=0,0", o_busy, o_integration); end
    n_tests++; if (o_row_addr !== 10'd1) begin n_fail++; $display("FAIL abort_row_addr got=%0d exp=1", o_row_addr); end
    clear_stats();
    observe(150, 1'b0);
    n_tests++; if (fd_cnt != 0 || rd_cnt != 0) begin n_fail++; $display("FAIL abort_no_done frames=%0d rows=%0d exp=0,0", fd_cnt, rd_cnt); end
    n_tests++; if (busy_hi != 0 || rise_cnt != 0) begin n_fail++; $display("FAIL abort_start_ignored busy_cycles=%0d rises=%0d exp=0,0", busy_hi, rise_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    mode = 1;
    start_frame(10'd3, 24'd10, 24'd5);
    observe(129, 1'b0);
    n_tests++; if (o_integration !== 1'b1 || o_row_addr !== 10'd1) begin n_fail++; $display("FAIL rstmid_pre int=%b row=%0d exp int=1 row=1", o_integration, o_row_addr); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (outs !== zeros) begin n_fail++; $display("FAIL rstmid_async outs=%h exp=%h", outs, zeros); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    start_frame(10'd1, 24'd0, 24'd0);
    observe(200, 1'b1);
    n_tests++; if (first_rise != 2 || fd_k != 93 || rd_cnt != 1) begin
      n_fail++; $display("FAIL rstmid_clean_frame rise=%0d done=%0d rows=%0d exp 2,93,1", first_rise, fd_k, rd_cnt); end
  endtask

  task automatic test_early_running;
    mode = 2;
    start_frame(10'd1, 24'd0, 24'd0);
    observe(19, 1'b0);
    num_rows = 10'd5;
    exposure = 24'd100;
    start    = 1'b1;
    observe(1, 1'b0);
    start = 1'b0;
    observe(39, 1'b0);
    start = 1'b1;
    observe(1, 1'b0);
    start = 1'b0;
    observe(200, 1'b1);
    n_tests++; if (err_k != -1 || fd_k != 93) begin n_fail++; $display("FAIL early_frame err_at=%0d done=%0d exp -1,93", err_k, fd_k); end
    n_tests++; if (rise_cnt != 1 || rd_cnt != 1 || fd_cnt != 1) begin
      n_fail++; $display("FAIL early_counts rises=%0d rows=%0d frames=%0d exp 1,1,1", rise_cnt, rd_cnt, fd_cnt); end
    n_tests++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL early_busy_after got=%b exp=0", busy_after); end
  endtask

  initial begin
    clear_stats();
    g_k = 0;
    test_reset();
    test_basic_frame();
    test_zero_cases();
    test_timeout();
    test_abort();
    test_reset_mid_frame();
    test_early_running();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
